control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Hardwired control sequencer driving every datapath control strobe; the datapath is currently stepped by hand-written T-state benches.
- Fetches into IR and decodes IR[31:27].
- Steps one T-state per clk and emits Moore-decoded strobes and ALU opcode per state.
- Replaces manual stimulus so programs run from memory unattended.

Parameters:
- ALU_W, 5, width of alu_op (matches datapath opcode input)

Ports:
- clk  input  1  system clock, all state changes on posedge
- clr  input  1  reset, asynchronous, active-low
- ir  input  32  instruction register contents (opcode = ir[31:27])
- con_ff  input  1  branch-condition flip-flop from datapath
- Gra, Grb, Grc, Rin, Rout, BAout  output  1 each  register-file select/enable strobes
- PCout, PCin, incPC, IRin, MARin, MDRin, MDRout, Yin, Zin  output  1 each  datapath register strobes
- ZLowOut, ZHighOut, HIin, LOin, HIout, LOout, Cout, CONN_in  output  1 each  datapath strobes
- read, write  output  1 each  memory strobes
- InPortOut, OutPortIn  output  1 each  I/O strobes
- alu_op  output  ALU_W  ALU function (nop 0, add 1, sub 2, mul 3, div 4, shr 5, shl 6, shra 7, ror 8, rol 9, and 10, or 11, neg 12, not 15)
- run  output  1  high while executing, low in reset/halt
- instr_done  output  1  one-cycle pulse in final state of each instruction

Behaviour:
- States: RST, T0..T7, HALT. clr low → RST immediately; all outputs 0 in RST/HALT; alu_op=0 unless listed.
- RST → T0 on first posedge after clr high. run=1 in T0..T7.
- Reset mid-instruction aborts with no partial strobes.
- Fetch:
  - T0: PCout MARin incPC Zin.
  - T1: ZLowOut PCin read MDRin.
  - T2: MDRout IRin.
  - T3 decodes ir[31:27], sampled only from T3 on.
- Instruction opcodes: ld 0, ldi 1, st 2, add 3, sub 4, and 5, or 6, shr 7, shra 8, shl 9, ror 10, rol 11, addi 12, andi 13, ori 14, mul 15, div 16, neg 17, not 18, br 19, jr 20, in 22, out 23, mfhi 24, mflo 25, nop 26, halt 27; any other value executes as nop.
- Execute sequences; the last listed state asserts instr_done and returns to T0:
  - reg ALU ops (add..rol): T3 Grb Rout Yin; T4 Grc Rout Zin alu_op=op; T5 ZLowOut Gra Rin.
  - addi/andi/ori: T3 Grb Rout Yin; T4 Cout Zin alu_op=add/and/or; T5 ZLowOut Gra Rin.
  - mul/div: T3 Gra Rout Yin; T4 Grb Rout Zin alu_op; T5 ZLowOut LOin; T6 ZHighOut HIin.
  - neg/not: T3 Grb Rout Zin alu_op; T4 ZLowOut Gra Rin.
  - ld: T3 Grb BAout Yin; T4 Cout Zin add; T5 ZLowOut MARin; T6 read MDRin; T7 MDRout Gra Rin.
  - ldi: T3–T4 as ld; T5 ZLowOut Gra Rin.
  - st: T3–T5 as ld; T6 Gra Rout MDRin (read=0); T7 write.
  - br: T3 Gra Rout CONN_in; T4 PCout Yin; T5 Cout Zin add; T6 ZLowOut, with PCin only if con_ff=1 (sampled in T6).
  - jr: T3 Gra Rout PCin.
  - in: T3 InPortOut Gra Rin. out: T3 Gra Rout OutPortIn.
  - mfhi: T3 HIout Gra Rin. mflo: T3 LOout Gra Rin.
  - nop: T3 instr_done only.
  - halt: T3 → HALT; HALT holds until clr low.
- Exactly one bus driver asserted per state.

Decomposition:
- Package cpu_defs_pkg holds instruction opcodes, ALU opcodes and state encodings; the datapath and benches share it.
- Single module: state register plus combinational output/next-state decode. No sub-module.

Test Plan:
- clr low mid-T4 of add → all outputs 0 immediately; after release, first posedge is T0, run=1.
- Memory word 9B180019 (brmi R6,25), R6=1 → con_ff=0, no PCin in T6, PC = fetch address+1.
- Same word, R6=0xFFFFFFFF → PCin in T6, PC = fetch address+1+25.
- ld R1,0x54(R0) with mem[0x54]=0x97 → R1=0x97 after T7; instr_done pulses exactly once.
- mul R3,R4 with R3=6, R4=-2 → LO=0xFFFFFFF4, HI=0xFFFFFFFF; 7 cycles total.
- halt (opcode 27) → run falls at T3 exit, strobes stay 0 for 20 cycles; undefined opcode 31 behaves as nop.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// +--------------------------------------------------------------------+
// | cpu_defs_pkg : instruction opcodes, ALU opcodes, sequencer states  |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
`default_nettype none

package cpu_defs_pkg;

  // Instruction opcodes, taken from ir[31:27]
  localparam logic [4:0] c_OP_LD   = 5'd0;
  localparam logic [4:0] c_OP_LDI  = 5'd1;
  localparam logic [4:0] c_OP_ST   = 5'd2;
  localparam logic [4:0] c_OP_ADD  = 5'd3;
  localparam logic [4:0] c_OP_SUB  = 5'd4;
  localparam logic [4:0] c_OP_AND  = 5'd5;
  localparam logic [4:0] c_OP_OR   = 5'd6;
  localparam logic [4:0] c_OP_SHR  = 5'd7;
  localparam logic [4:0] c_OP_SHRA = 5'd8;
  localparam logic [4:0] c_OP_SHL  = 5'd9;
  localparam logic [4:0] c_OP_ROR  = 5'd10;
  localparam logic [4:0] c_OP_ROL  = 5'd11;
  localparam logic [4:0] c_OP_ADDI = 5'd12;
  localparam logic [4:0] c_OP_ANDI = 5'd13;
  localparam logic [4:0] c_OP_ORI  = 5'd14;
  localparam logic [4:0] c_OP_MUL  = 5'd15;
  localparam logic [4:0] c_OP_DIV  = 5'd16;
  localparam logic [4:0] c_OP_NEG  = 5'd17;
  localparam logic [4:0] c_OP_NOT  = 5'd18;
  localparam logic [4:0] c_OP_BR   = 5'd19;
  localparam logic [4:0] c_OP_JR   = 5'd20;
  localparam logic [4:0] c_OP_IN   = 5'd22;
  localparam logic [4:0] c_OP_OUT  = 5'd23;
  localparam logic [4:0] c_OP_MFHI = 5'd24;
  localparam logic [4:0] c_OP_MFLO = 5'd25;
  localparam logic [4:0] c_OP_NOP  = 5'd26;
  localparam logic [4:0] c_OP_HALT = 5'd27;

  // ALU function codes seen by the datapath
  localparam logic [4:0] c_ALU_NOP  = 5'd0;
  localparam logic [4:0] c_ALU_ADD  = 5'd1;
  localparam logic [4:0] c_ALU_SUB  = 5'd2;
  localparam logic [4:0] c_ALU_MUL  = 5'd3;
  localparam logic [4:0] c_ALU_DIV  = 5'd4;
  localparam logic [4:0] c_ALU_SHR  = 5'd5;
  localparam logic [4:0] c_ALU_SHL  = 5'd6;
  localparam logic [4:0] c_ALU_SHRA = 5'd7;
  localparam logic [4:0] c_ALU_ROR  = 5'd8;
  localparam logic [4:0] c_ALU_ROL  = 5'd9;
  localparam logic [4:0] c_ALU_AND  = 5'd10;
  localparam logic [4:0] c_ALU_OR   = 5'd11;
  localparam logic [4:0] c_ALU_NEG  = 5'd12;
  localparam logic [4:0] c_ALU_NOT  = 5'd15;

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_HALT = 4'd9
  } state_t;

  // ALU function for the compute step of an arithmetic/logic instruction
  function automatic logic [4:0] alu_for_op(input logic [4:0] op);
    case (op)
      c_OP_ADD, c_OP_ADDI: alu_for_op = c_ALU_ADD;
      c_OP_SUB:            alu_for_op = c_ALU_SUB;
      c_OP_AND, c_OP_ANDI: alu_for_op = c_ALU_AND;
      c_OP_OR,  c_OP_ORI:  alu_for_op = c_ALU_OR;
      c_OP_SHR:            alu_for_op = c_ALU_SHR;
      c_OP_SHRA:           alu_for_op = c_ALU_SHRA;
      c_OP_SHL:            alu_for_op = c_ALU_SHL;
      c_OP_ROR:            alu_for_op = c_ALU_ROR;
      c_OP_ROL:            alu_for_op = c_ALU_ROL;
      c_OP_MUL:            alu_for_op = c_ALU_MUL;
      c_OP_DIV:            alu_for_op = c_ALU_DIV;
      c_OP_NEG:            alu_for_op = c_ALU_NEG;
      c_OP_NOT:            alu_for_op = c_ALU_NOT;
      default:             alu_for_op = c_ALU_NOP;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/control_unit.sv
// +--------------------------------------------------------------------+
// | control_unit : hardwired T-state sequencer with Moore strobes      |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
`default_nettype none

module control_unit
  import cpu_defs_pkg::*;
#(
  parameter int ALU_W = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      ir,
  input  logic             con_ff,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic             BAout,
  output logic             PCout,
  output logic             PCin,
  output logic             incPC,
  output logic             IRin,
  output logic             MARin,
  output logic             MDRin,
  output logic             MDRout,
  output logic             Yin,
  output logic             Zin,
  output logic             ZLowOut,
  output logic             ZHighOut,
  output logic             HIin,
  output logic             LOin,
  output logic             HIout,
  output logic             LOout,
  output logic             Cout,
  output logic             CONN_in,
  output logic             read,
  output logic             write,
  output logic             InPortOut,
  output logic             OutPortIn,
  output logic [ALU_W-1:0] alu_op,
  output logic             run,
  output logic             instr_done
);

  state_t     r_state;
  state_t     w_next;
  logic [4:0] w_op;
  logic [4:0] w_alu;
  logic       w_unused_ir;

  assign w_op        = ir[31:27];
  assign w_alu       = alu_for_op(w_op);
  assign w_unused_ir = ^ir[26:0];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= ST_RST;
    else      r_state <= w_next;
  end

  always_comb begin
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    PCout = 1'b0; PCin = 1'b0; incPC = 1'b0; IRin = 1'b0; MARin = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; Yin = 1'b0; Zin = 1'b0;
    ZLowOut = 1'b0; ZHighOut = 1'b0; HIin = 1'b0; LOin = 1'b0;
    HIout = 1'b0; LOout = 1'b0; Cout = 1'b0; CONN_in = 1'b0;
    read = 1'b0; write = 1'b0; InPortOut = 1'b0; OutPortIn = 1'b0;
    alu_op = '0; run = 1'b0; instr_done = 1'b0;
    w_next = r_state;

    case (r_state)
      ST_RST: w_next = ST_T0;
      ST_T0: begin
        run = 1'b1; w_next = ST_T1;
        PCout = 1'b1; MARin = 1'b1; incPC = 1'b1; Zin = 1'b1;
      end
      ST_T1: begin
        run = 1'b1; w_next = ST_T2;
        ZLowOut = 1'b1; PCin = 1'b1; read = 1'b1; MDRin = 1'b1;
      end
      ST_T2: begin
        run = 1'b1; w_next = ST_T3;
        MDRout = 1'b1; IRin = 1'b1;
      end
      ST_T3: begin
        run = 1'b1; w_next = ST_T4;
        case (w_op)
          c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_SHR, c_OP_SHRA,
          c_OP_SHL, c_OP_ROR, c_OP_ROL, c_OP_ADDI, c_OP_ANDI, c_OP_ORI: begin
            Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
          end
          c_OP_MUL, c_OP_DIV: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          c_OP_NEG, c_OP_NOT: begin
            Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = ALU_W'(w_alu);
          end
          c_OP_LD, c_OP_LDI, c_OP_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          c_OP_BR:   begin Gra = 1'b1; Rout = 1'b1; CONN_in = 1'b1; end
          c_OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; instr_done = 1'b1; end
          c_OP_IN:   begin InPortOut = 1'b1; Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1; end
          c_OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1; instr_done = 1'b1; end
          c_OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1; end
          c_OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1; end
          c_OP_HALT: w_next = ST_HALT;
          // nop and every unassigned opcode
          default:   instr_done = 1'b1;
        endcase
      end
      ST_T4: begin
        run = 1'b1; w_next = ST_T5;
        case (w_op)
          c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_SHR, c_OP_SHRA,
          c_OP_SHL, c_OP_ROR, c_OP_ROL: begin
            Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = ALU_W'(w_alu);
          end
          c_OP_ADDI, c_OP_ANDI, c_OP_ORI: begin
            Cout = 1'b1; Zin = 1'b1; alu_op = ALU_W'(w_alu);
          end
          c_OP_MUL, c_OP_DIV: begin
            Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = ALU_W'(w_alu);
          end
          c_OP_NEG, c_OP_NOT: begin
            ZLowOut = 1'b1; Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1;
          end
          c_OP_LD, c_OP_LDI, c_OP_ST: begin
            Cout = 1'b1; Zin = 1'b1; alu_op = ALU_W'(c_ALU_ADD);
          end
          c_OP_BR: begin PCout = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      end
      ST_T5: begin
        run = 1'b1; w_next = ST_T6;
        case (w_op)
          c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_SHR, c_OP_SHRA,
          c_OP_SHL, c_OP_ROR, c_OP_ROL, c_OP_ADDI, c_OP_ANDI, c_OP_ORI,
          c_OP_LDI: begin
            ZLowOut = 1'b1; Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1;
          end
          c_OP_MUL, c_OP_DIV: begin ZLowOut = 1'b1; LOin = 1'b1; end
          c_OP_LD, c_OP_ST:   begin ZLowOut = 1'b1; MARin = 1'b1; end
          c_OP_BR: begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_W'(c_ALU_ADD); end
          default: ;
        endcase
      end
      ST_T6: begin
        run = 1'b1; w_next = ST_T7;
        case (w_op)
          c_OP_MUL, c_OP_DIV: begin ZHighOut = 1'b1; HIin = 1'b1; instr_done = 1'b1; end
          c_OP_LD: begin read = 1'b1; MDRin = 1'b1; end
          c_OP_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          // branch target is loaded only when the condition flop is set
          c_OP_BR: begin ZLowOut = 1'b1; PCin = con_ff; instr_done = 1'b1; end
          default: ;
        endcase
      end
      ST_T7: begin
        run = 1'b1; w_next = ST_T0;
        case (w_op)
          c_OP_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1; end
          c_OP_ST: begin write = 1'b1; instr_done = 1'b1; end
          default: ;
        endcase
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_RST;
    endcase

    if (instr_done) w_next = ST_T0;
  end

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// +--------------------------------------------------------------------+
// | tb_control_unit : randomized bench with per-instruction reference  |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_control_unit;

  localparam int ALU_W = 5;

  // Bit positions of the packed strobe vector compared each cycle
  localparam logic [28:0] GRA     = 29'd1 << 0;
  localparam logic [28:0] GRB     = 29'd1 << 1;
  localparam logic [28:0] GRC     = 29'd1 << 2;
  localparam logic [28:0] RIN     = 29'd1 << 3;
  localparam logic [28:0] ROUT    = 29'd1 << 4;
  localparam logic [28:0] BAOUT   = 29'd1 << 5;
  localparam logic [28:0] PCOUT   = 29'd1 << 6;
  localparam logic [28:0] PCIN    = 29'd1 << 7;
  localparam logic [28:0] INCPC   = 29'd1 << 8;
  localparam logic [28:0] IRIN    = 29'd1 << 9;
  localparam logic [28:0] MARIN   = 29'd1 << 10;
  localparam logic [28:0] MDRIN   = 29'd1 << 11;
  localparam logic [28:0] MDROUT  = 29'd1 << 12;
  localparam logic [28:0] YIN     = 29'd1 << 13;
  localparam logic [28:0] ZIN     = 29'd1 << 14;
  localparam logic [28:0] ZLOW    = 29'd1 << 15;
  localparam logic [28:0] ZHIGH   = 29'd1 << 16;
  localparam logic [28:0] HIIN    = 29'd1 << 17;
  localparam logic [28:0] LOIN    = 29'd1 << 18;
  localparam logic [28:0] HIOUT   = 29'd1 << 19;
  localparam logic [28:0] LOOUT   = 29'd1 << 20;
  localparam logic [28:0] COUT    = 29'd1 << 21;
  localparam logic [28:0] CONN    = 29'd1 << 22;
  localparam logic [28:0] READ    = 29'd1 << 23;
  localparam logic [28:0] WRITE   = 29'd1 << 24;
  localparam logic [28:0] INPORT  = 29'd1 << 25;
  localparam logic [28:0] OUTPORT = 29'd1 << 26;
  localparam logic [28:0] RUN     = 29'd1 << 27;
  localparam logic [28:0] DONE    = 29'd1 << 28;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic [31:0] ir = 32'd0;
  logic con_ff = 1'b0;
  logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, incPC, IRin, MARin;
  logic MDRin, MDRout, Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, HIout, LOout;
  logic Cout, CONN_in, read, write, InPortOut, OutPortIn, run, instr_done;
  logic [ALU_W-1:0] alu_op;
  logic [28:0] dut_s;

  control_unit #(.ALU_W(ALU_W)) dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .PCin(PCin), .incPC(incPC), .IRin(IRin), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .Yin(Yin), .Zin(Zin),
    .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .HIin(HIin), .LOin(LOin),
    .HIout(HIout), .LOout(LOout), .Cout(Cout), .CONN_in(CONN_in),
    .read(read), .write(write), .InPortOut(InPortOut), .OutPortIn(OutPortIn),
    .alu_op(alu_op), .run(run), .instr_done(instr_done)
  );

  assign dut_s = {instr_done, run, OutPortIn, InPortOut, write, read, CONN_in, Cout,
                  LOout, HIout, LOin, HIin, ZHighOut, ZLowOut, Zin, Yin, MDRout,
                  MDRin, MARin, IRin, incPC, PCin, PCout, BAout, Rout, Rin, Grc, Grb, Gra};

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [28:0] s;
    logic [4:0]  alu;
    bit          brc;
  } ent_t;

  ent_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ex(input logic [28:0] m, input logic [4:0] a = 5'd0,
                             input bit b = 1'b0);
    ent_t e;
    e.s = m | RUN; e.alu = a; e.brc = b;
    q.push_back(e);
  endfunction

  // Reference: the whole per-cycle strobe sequence of one instruction
  function automatic void push_instr(input logic [4:0] op);
    logic [4:0] a;
    q.delete();
    ex(PCOUT | MARIN | INCPC | ZIN);
    ex(ZLOW | PCIN | READ | MDRIN);
    ex(MDROUT | IRIN);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin
        case (op)
          5'd3: a = 5'd1;  5'd4: a = 5'd2;  5'd5: a = 5'd10;
          5'd6: a = 5'd11; 5'd7: a = 5'd5;  5'd8: a = 5'd7;
          5'd9: a = 5'd6;  5'd10: a = 5'd8; default: a = 5'd9;
        endcase
        ex(GRB | ROUT | YIN); ex(GRC | ROUT | ZIN, a); ex(ZLOW | GRA | RIN);
      end
      5'd12, 5'd13, 5'd14: begin
        a = (op == 5'd12) ? 5'd1 : (op == 5'd13) ? 5'd10 : 5'd11;
        ex(GRB | ROUT | YIN); ex(COUT | ZIN, a); ex(ZLOW | GRA | RIN);
      end
      5'd15, 5'd16: begin
        ex(GRA | ROUT | YIN); ex(GRB | ROUT | ZIN, (op == 5'd15) ? 5'd3 : 5'd4);
        ex(ZLOW | LOIN); ex(ZHIGH | HIIN);
      end
      5'd17, 5'd18: begin
        ex(GRB | ROUT | ZIN, (op == 5'd17) ? 5'd12 : 5'd15); ex(ZLOW | GRA | RIN);
      end
      5'd0, 5'd1, 5'd2: begin
        ex(GRB | BAOUT | YIN); ex(COUT | ZIN, 5'd1);
        if (op == 5'd1) ex(ZLOW | GRA | RIN);
        else begin
          ex(ZLOW | MARIN);
          if (op == 5'd0) begin ex(READ | MDRIN); ex(MDROUT | GRA | RIN); end
          else begin ex(GRA | ROUT | MDRIN); ex(WRITE); end
        end
      end
      5'd19: begin
        ex(GRA | ROUT | CONN); ex(PCOUT | YIN); ex(COUT | ZIN, 5'd1); ex(ZLOW, 5'd0, 1'b1);
      end
      5'd20: ex(GRA | ROUT | PCIN);
      5'd22: ex(INPORT | GRA | RIN);
      5'd23: ex(GRA | ROUT | OUTPORT);
      5'd24: ex(HIOUT | GRA | RIN);
      5'd25: ex(LOOUT | GRA | RIN);
      default: ex(29'd0);
    endcase
    if (op != 5'd27) q[q.size()-1].s = q[q.size()-1].s | DONE;
  endfunction

  // Run one instruction from T0; optionally pull clr low mid-cycle after step abort_at
  task automatic run_instr(input logic [31:0] word, input int con_mode, input int abort_at,
                           output int cycles, output int dones, output logic [28:0] first_s,
                           output logic [28:0] last_s, output bit aborted);
    int idx;
    ent_t e;
    logic [28:0] es;
    idx = 0; cycles = 0; dones = 0; first_s = '0; last_s = '0; aborted = 1'b0;
    push_instr(word[31:27]);
    while (q.size() > 0) begin
      @(negedge clk);
      ir = (idx < 3) ? $urandom : word;
      con_ff = (con_mode < 0) ? 1'($urandom_range(0, 1)) : 1'(con_mode);
      #1;
      e = q.pop_front();
      es = e.s | ((e.brc && con_ff) ? PCIN : 29'd0);
      chk("strobes", {3'd0, dut_s}, {3'd0, es});
      chk("alu_op", 32'(alu_op), 32'(e.alu));
      cycles++;
      if (instr_done) dones++;
      if (idx == 0) first_s = dut_s;
      last_s = dut_s;
      if (idx == abort_at) begin
        #2 clr = 1'b0;
        #1;
        chk("abort_strobes", {3'd0, dut_s}, 32'd0);
        chk("abort_alu", 32'(alu_op), 32'd0);
        q.delete();
        aborted = 1'b1;
      end
      idx++;
    end
  endtask

  task automatic idle_zero(input int n, input string name);
    repeat (n) begin
      @(negedge clk);
      ir = $urandom;
      con_ff = 1'($urandom_range(0, 1));
      #1;
      chk(name, {3'd0, dut_s}, 32'd0);
      chk({name, "_alu"}, 32'(alu_op), 32'd0);
    end
  endtask

  task automatic release_rst(input int hold);
    idle_zero(hold, "rst_hold");
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("rst_release", {3'd0, dut_s}, 32'd0);
  endtask

  task automatic async_rst();
    @(negedge clk);
    #3 clr = 1'b0;
    #1;
    chk("async_rst", {3'd0, dut_s}, 32'd0);
  endtask

  initial begin
    int cyc, dn, abort_at;
    logic [28:0] fs, ls;
    bit ab;
    logic [4:0] op;

    #1 clr = 1'b0;
    release_rst(2);

    // brmi R6,25 not taken, then taken
    run_instr(32'h9B180019, 0, -1, cyc, dn, fs, ls, ab);
    chk("br_nt_pcin", 32'(ls[7]), 32'd0);
    chk("br_nt_zlow", 32'(ls[15]), 32'd1);
    chk("br_cycles", 32'(cyc), 32'd7);
    run_instr(32'h9B180019, 1, -1, cyc, dn, fs, ls, ab);
    chk("br_t_pcin", 32'(ls[7]), 32'd1);

    // ld R1,0x54(R0)
    run_instr(32'h00800054, -1, -1, cyc, dn, fs, ls, ab);
    chk("ld_cycles", 32'(cyc), 32'd8);
    chk("ld_done_once", 32'(dn), 32'd1);
    chk("ld_t7_rin", 32'(ls[3]), 32'd1);

    // mul R3,R4
    run_instr(32'h79A00000, -1, -1, cyc, dn, fs, ls, ab);
    chk("mul_cycles", 32'(cyc), 32'd7);
    chk("mul_done_once", 32'(dn), 32'd1);
    chk("mul_t6_hiin", 32'(ls[17]), 32'd1);

    // undefined opcode 31 runs as nop
    run_instr(32'hF8000000, -1, -1, cyc, dn, fs, ls, ab);
    chk("op31_cycles", 32'(cyc), 32'd4);
    chk("op31_done", 32'(dn), 32'd1);

    // add aborted by clr in the middle of T4
    run_instr(32'h18000000, -1, 4, cyc, dn, fs, ls, ab);
    chk("add_aborted", 32'(ab), 32'd1);
    release_rst(2);
    run_instr(32'h68000000, -1, -1, cyc, dn, fs, ls, ab);
    chk("t0_run_after_rst", 32'(fs[27]), 32'd1);
    chk("t0_pcout_after_rst", 32'(fs[6]), 32'd1);

    // halt
    run_instr(32'hD8000000, -1, -1, cyc, dn, fs, ls, ab);
    chk("halt_cycles", 32'(cyc), 32'd4);
    chk("halt_no_done", 32'(dn), 32'd0);
    chk("halt_t3_run", 32'(ls[27]), 32'd1);
    idle_zero(20, "halt_idle");
    async_rst();
    release_rst(1);

    // randomized instruction stream with occasional mid-instruction reset
    for (int i = 0; i < 400; i++) begin
      op = 5'($urandom_range(0, 31));
      abort_at = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_instr({op, 27'($urandom)}, -1, abort_at, cyc, dn, fs, ls, ab);
      if (ab) release_rst(1);
      else if (op == 5'd27) begin
        idle_zero(3, "halt_idle_rnd");
        async_rst();
        release_rst(1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
